// File: rtl/equiv_sweep_checker.sv
// Exhaustive equivalence checker: sweeps vec through 0..2^N-1, holds each value
// HOLD cycles, compares two combinational responses on the last hold cycle.
module equiv_sweep_checker #(
    parameter int N    = 3,
    parameter int M    = 1,
    parameter int HOLD = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] vec,
    input  logic [M-1:0] resp_a,
    input  logic [M-1:0] resp_b,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_fail,
    output logic         fail_valid
);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HLAST = HW'(HOLD - 1);
    localparam logic [N-1:0]  VLAST = {N{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [N-1:0]  vec_q, vec_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [N:0]    err_q, err_d;
    logic [N-1:0]  ff_q;
    logic          fv_q, busy_q, done_q;
    logic          mismatch;

    assign mismatch = (resp_a != resp_b);
    assign vec_d    = vec_q + 1'b1;
    assign hcnt_d   = hcnt_q + 1'b1;
    // A vector counts once however many response bits differ.
    assign err_d    = err_q + {{N{1'b0}}, mismatch};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            hcnt_q  <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        vec_q   <= '0;
                        hcnt_q  <= '0;
                        err_q   <= '0;
                        ff_q    <= '0;
                        fv_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (hcnt_q == HLAST) begin
                        err_q <= err_d;
                        if (mismatch && !fv_q) begin
                            ff_q <= vec_q;
                            fv_q <= 1'b1;
                        end
                        if (vec_q == VLAST) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            vec_q  <= vec_d;
                            hcnt_q <= '0;
                        end
                    end else begin
                        hcnt_q <= hcnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vec        = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign fail_valid = fv_q;
    assign pass       = done_q && (err_q == '0);
endmodule

// File: tb/tb_equiv_sweep_checker.sv
// Directed bench for equiv_sweep_checker: two instances (HOLD=1/M=1, HOLD=3/M=2)
// with expected sweep results queued at start and popped when done rises.
module tb_equiv_sweep_checker;
    logic       clk = 1'b0;
    logic       rst, start0, start1;
    logic [2:0] vec0, vec1, ff0, ff1;
    logic       ra0, rb0;
    logic [1:0] ra1, rb1;
    logic       busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
    logic [3:0] err0, err1;
    int         mode;
    int         tsel;
    int         passed = 0, total = 0;

    typedef struct {int err; int ff; bit fv; int cyc; int fvj;} exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    // Reference a&(b&c) vs (a&b)&c, with optional injected faults.
    always_comb begin
        ra0 = vec0[0] & (vec0[1] & vec0[2]);
        rb0 = (vec0[0] & vec0[1]) & vec0[2];
        if (mode == 1)      rb0 = rb0 ^ (vec0 == 3'd5);
        else if (mode == 2) rb0 = ~rb0;
        ra1 = {vec1[1] ^ vec1[2], vec1[0] | vec1[2]};
        rb1 = ra1 ^ {(vec1 == 3'd2) || (vec1 == 3'd6), 1'b0};
    end

    equiv_sweep_checker #(.N(3), .M(1), .HOLD(1)) u0 (
        .clk(clk), .rst(rst), .start(start0), .vec(vec0), .resp_a(ra0), .resp_b(rb0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail(ff0), .fail_valid(fv0));

    equiv_sweep_checker #(.N(3), .M(2), .HOLD(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .vec(vec1), .resp_a(ra1), .resp_b(rb1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail(ff1), .fail_valid(fv1));

    logic       c_busy, c_done, c_pass, c_fv;
    logic [2:0] c_vec, c_ff;
    logic [3:0] c_err;
    always_comb begin
        c_busy = (tsel == 1) ? busy1 : busy0;
        c_done = (tsel == 1) ? done1 : done0;
        c_pass = (tsel == 1) ? pass1 : pass0;
        c_fv   = (tsel == 1) ? fv1   : fv0;
        c_vec  = (tsel == 1) ? vec1  : vec0;
        c_ff   = (tsel == 1) ? ff1   : ff0;
        c_err  = (tsel == 1) ? err1  : err0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic bit mis(input int sel, input int m, input int v);
        if (sel == 1) return (v == 2) || (v == 6);
        if (m == 1)   return v == 5;
        return m == 2;
    endfunction

    task automatic set_start(input int sel, input logic val);
        if (sel == 1) start1 = val;
        else          start0 = val;
    endtask

    // Runs one sweep from IDLE/DONE; spa = edge index (after start) at which a stray start is pulsed.
    task automatic sweep(input string nm, input int sel, input int m, input int spa);
        exp_t e, g;
        int hold, j, bad, fvj;
        hold = (sel == 1) ? 3 : 1;
        tsel = sel;
        mode = m;
        e = '{err: 0, ff: 0, fv: 1'b0, cyc: 8 * hold, fvj: -1};
        for (int v = 0; v < 8; v++)
            if (mis(sel, m, v)) begin
                if (!e.fv) begin e.ff = v; e.fv = 1'b1; e.fvj = (v + 1) * hold; end
                e.err++;
            end
        q.push_back(e);
        set_start(sel, 1'b1);
        step();
        set_start(sel, 1'b0);
        chk({nm, ".start_busy"}, c_busy, 1);
        chk({nm, ".start_vec"}, c_vec, 0);
        chk({nm, ".start_cleared"}, {c_done, c_fv, c_err}, 0);
        j = 0; bad = 0; fvj = -1;
        while (!c_done && j < 400) begin
            if (j == spa) set_start(sel, 1'b1);
            step();
            set_start(sel, 1'b0);
            j++;
            if (!c_done && c_vec != 3'(j / hold)) bad++;
            if (c_busy && c_pass) bad++;
            if (c_fv && fvj < 0) fvj = j;
        end
        g = q.pop_front();
        chk({nm, ".latency"}, j, g.cyc);
        chk({nm, ".vec_seq"}, bad, 0);
        chk({nm, ".err_count"}, c_err, g.err);
        chk({nm, ".fail_valid"}, c_fv, g.fv);
        if (g.fv) chk({nm, ".first_fail"}, c_ff, g.ff);
        chk({nm, ".fv_edge"}, fvj, g.fvj);
        chk({nm, ".pass"}, c_pass, (g.err == 0) ? 1 : 0);
        chk({nm, ".busy_done"}, {c_busy, c_done}, 1);
        chk({nm, ".vec_final"}, c_vec, 7);
    endtask

    initial begin
        mode = 0; tsel = 0;
        rst = 1'b1; start0 = 1'b1; start1 = 1'b0;
        step();
        start0 = 1'b0;
        chk("reset0", {vec0, busy0, done0, pass0, err0, ff0, fv0}, 0);
        chk("reset1", {vec1, busy1, done1, pass1, err1, ff1, fv1}, 0);
        rst = 1'b0;
        step();
        chk("idle_stays", {busy0, done0, vec0}, 0);

        sweep("ident", 0, 0, -1);
        sweep("vec5", 0, 1, -1);
        sweep("invert", 0, 2, -1);
        sweep("ignore_start", 0, 0, 5);
        sweep("restart", 0, 0, -1);
        sweep("hold3", 1, 0, -1);
        sweep("hold3_again", 1, 0, 4);

        // Abort mid-sweep once vec reaches 4.
        tsel = 0; mode = 1;
        start0 = 1'b1; step(); start0 = 1'b0;
        for (int i = 0; i < 20 && vec0 != 3'd4; i++) step();
        chk("abort_at4", vec0, 4);
        rst = 1'b1; start0 = 1'b1;
        step();
        rst = 1'b0; start0 = 1'b0;
        chk("abort_zero", {vec0, busy0, done0, pass0, err0, ff0, fv0}, 0);
        step();
        chk("abort_idle", {busy0, done0}, 0);
        sweep("after_abort", 0, 1, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
